// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared constants and helpers for the floating-point datapath.
// Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W_DEFAULT  = 8;
    localparam int MANT_W_DEFAULT = 24;

    // Encoding of the per-item diff output mode
    localparam logic MODE_MAG = 1'b0;   // |A-B|
    localparam logic MODE_RAW = 1'b1;   // two's-complement A-B

    // Alignment shift saturates past the mantissa plus guard and round bits
    function automatic int sat_limit(input int mant_w);
        return mant_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
// ============================================================================
// Module      : FullAdder
// Description : Single-bit full adder cell.
// Revision    : 1.0  initial release
// ============================================================================
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule
`default_nettype wire

// File: rtl/param_ripple_sub.sv
`default_nettype none
// ============================================================================
// Module      : param_ripple_sub
// Description : W-bit ripple subtractor Z = A - B, built as A + ~B + 1.
//               Cout = 1 means no borrow, i.e. A >= B.
// Revision    : 1.0  initial release
// ============================================================================
module param_ripple_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Z,
    output logic         Cout
);

    logic [W:0] w_carry;

    // The +1 of the two's-complement negation enters as the carry-in
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        FullAdder u_fa (
            .A    (A[i]),
            .B    (~B[i]),
            .Cin  (w_carry[i]),
            .S    (Z[i]),
            .Cout (w_carry[i+1])
        );
    end

    assign Cout = w_carry[W];

endmodule
`default_nettype wire

// File: rtl/exp_diff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : exp_diff_pipe
// Description : Two-stage pipelined exponent difference with valid/ready.
//               Stage 1 registers the raw borrow-chain subtract; stage 2
//               registers diff, saturated shift amount, order and equality.
// Revision    : 1.0  initial release
// ============================================================================
module exp_diff_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEFAULT,
    parameter int MANT_W = MANT_W_DEFAULT,
    parameter int SH_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] diff,
    output logic [SH_W-1:0]  shamt,
    output logic             a_lt_b,
    output logic             eq
);

    localparam int SAT = sat_limit(MANT_W);
    // Comparison width wide enough to hold both the magnitude and SAT
    localparam int CMP_W = (EXP_W > 32) ? EXP_W : 32;

    // The shift field must be able to encode the saturation value
    if ((1 << SH_W) <= SAT) begin : g_shw_check
        $error("exp_diff_pipe: SH_W too narrow for saturation value");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [EXP_W:0]   s1_raw_q,   s1_raw_d;
    logic             s1_mode_q,  s1_mode_d;

    logic             out_valid_q, out_valid_d;
    logic [EXP_W-1:0] diff_q,      diff_d;
    logic [SH_W-1:0]  shamt_q,     shamt_d;
    logic             a_lt_b_q,    a_lt_b_d;
    logic             eq_q,        eq_d;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_s2_load;
    logic w_s1_advance;
    logic w_accept;

    assign w_s2_load    = ~out_valid_q | out_ready;
    assign w_s1_advance = s1_valid_q & w_s2_load;
    assign in_ready     = ~s1_valid_q | w_s2_load;
    assign w_accept     = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1 subtractor
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_sub_z;
    logic             w_sub_cout;

    param_ripple_sub #(
        .W (EXP_W)
    ) u_sub (
        .A    (exp_a),
        .B    (exp_b),
        .Z    (w_sub_z),
        .Cout (w_sub_cout)
    );

    // ------------------------------------------------------------------
    // Stage 2 combinational result from the registered raw difference
    // ------------------------------------------------------------------
    logic             w_c;
    logic [EXP_W-1:0] w_z;
    logic [EXP_W-1:0] w_mag;
    logic [CMP_W-1:0] w_mag_ext;
    logic [EXP_W-1:0] w_diff;
    logic [SH_W-1:0]  w_shamt;

    // Decode magnitude, selected diff and saturated shift from stage 1
    always_comb begin
        w_c       = s1_raw_q[EXP_W];
        w_z       = s1_raw_q[EXP_W-1:0];
        w_mag     = w_c ? w_z : ({EXP_W{1'b0}} - w_z);
        w_mag_ext = CMP_W'(w_mag);
        w_diff    = (s1_mode_q == MODE_MAG) ? w_mag : w_z;
        w_shamt   = (w_mag_ext > CMP_W'(SAT)) ? SH_W'(SAT) : SH_W'(w_mag);
    end

    // Next-state for both stages: load on transfer, otherwise hold
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_raw_d    = s1_raw_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        shamt_d     = shamt_q;
        a_lt_b_d    = a_lt_b_q;
        eq_d        = eq_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_raw_d   = {w_sub_cout, w_sub_z};
            s1_mode_d  = mode;
        end else if (w_s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (w_s2_load) begin
            out_valid_d = s1_valid_q;
        end

        if (w_s1_advance) begin
            diff_d   = w_diff;
            shamt_d  = w_shamt;
            a_lt_b_d = ~w_c;
            eq_d     = (w_z == {EXP_W{1'b0}});
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_raw_q    <= '0;
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            shamt_q     <= '0;
            a_lt_b_q    <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_raw_q    <= s1_raw_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            shamt_q     <= shamt_d;
            a_lt_b_q    <= a_lt_b_d;
            eq_q        <= eq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign shamt     = shamt_q;
    assign a_lt_b    = a_lt_b_q;
    assign eq        = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_exp_diff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_diff_pipe
// Description : Directed self-checking bench for exp_diff_pipe (EXP_W=8,
//               MANT_W=24 so saturation is 26, SH_W=5).
// Revision    : 1.0  initial release
// ============================================================================
module tb_exp_diff_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic [4:0] shamt;
    logic       a_lt_b;
    logic       eq;

    int n_chk = 0;
    int n_err = 0;

    // Observed result word: {out_valid, diff, shamt, a_lt_b, eq}
    logic [15:0] obs;
    assign obs = {out_valid, diff, shamt, a_lt_b, eq};

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [7:0] d;
        logic [4:0] s;
        logic       lt;
        logic       e;
    } vec_t;

    exp_diff_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .shamt     (shamt),
        .a_lt_b    (a_lt_b),
        .eq        (eq)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic m);
        exp_a    = a;
        exp_b    = b;
        mode     = m;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", obs, 16'h0000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL post_reset_outputs: got %h want %h", obs, 16'h0000);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t t [13] = '{
            '{8'd130, 8'd127, 1'b0, 8'd3,   5'd3,  1'b0, 1'b0},
            '{8'd10,  8'd200, 1'b0, 8'd190, 5'd26, 1'b1, 1'b0},
            '{8'd10,  8'd200, 1'b1, 8'd66,  5'd26, 1'b1, 1'b0},
            '{8'd77,  8'd77,  1'b0, 8'd0,   5'd0,  1'b0, 1'b1},
            '{8'd77,  8'd77,  1'b1, 8'd0,   5'd0,  1'b0, 1'b1},
            '{8'd255, 8'd0,   1'b0, 8'd255, 5'd26, 1'b0, 1'b0},
            '{8'd0,   8'd255, 1'b1, 8'd1,   5'd26, 1'b1, 1'b0},
            '{8'd0,   8'd255, 1'b0, 8'd255, 5'd26, 1'b1, 1'b0},
            '{8'd100, 8'd74,  1'b0, 8'd26,  5'd26, 1'b0, 1'b0},
            '{8'd100, 8'd73,  1'b0, 8'd27,  5'd26, 1'b0, 1'b0},
            '{8'd74,  8'd99,  1'b0, 8'd25,  5'd25, 1'b1, 1'b0},
            '{8'd50,  8'd60,  1'b1, 8'd246, 5'd10, 1'b1, 1'b0},
            '{8'd1,   8'd0,   1'b1, 8'd1,   5'd1,  1'b0, 1'b0}
        };
        out_ready = 1'b1;
        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i].a, t[i].b, t[i].m);
            #1;
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid);
            end
            @(negedge clk);
            n_chk++;
            if (obs !== {1'b1, t[i].d, t[i].s, t[i].lt, t[i].e}) begin
                n_err++;
                $display("FAIL dir%0d_result: got %h want %h", i, obs,
                         {1'b1, t[i].d, t[i].s, t[i].lt, t[i].e});
            end
        end
    endtask

    task automatic test_backpressure();
        // Expected words for items I0..I3
        logic [15:0] e0 = {1'b1, 8'd15,  5'd15, 1'b0, 1'b0};  // 20 - 5
        logic [15:0] e1 = {1'b1, 8'd15,  5'd15, 1'b1, 1'b0};  // 5 - 20
        logic [15:0] e2 = {1'b1, 8'd100, 5'd26, 1'b0, 1'b0};  // 200 - 100
        logic [15:0] e3 = {1'b1, 8'd255, 5'd1,  1'b1, 1'b0};  // 1 - 2 raw
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(8'd20, 8'd5, 1'b0);
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept0: got %b want 1", in_ready);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_early_valid: got %b want 0", out_valid);
        end
        drive(8'd5, 8'd20, 1'b0);
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept1: got %b want 1", in_ready);
        end
        @(negedge clk);
        drive(8'd200, 8'd100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_chk++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_full_in_ready%0d: got %b want 0", k, in_ready);
            end
            n_chk++;
            if (obs !== e0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got %h want %h", k, obs, e0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        drive(8'd1, 8'd2, 1'b1);
        n_chk++;
        if (obs !== e1) begin
            n_err++;
            $display("FAIL bp_out1: got %h want %h", obs, e1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (obs !== e2) begin
            n_err++;
            $display("FAIL bp_out2: got %h want %h", obs, e2);
        end
        @(negedge clk);
        n_chk++;
        if (obs !== e3) begin
            n_err++;
            $display("FAIL bp_out3: got %h want %h", obs, e3);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_duplicate: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        vec_t t [8] = '{
            '{8'd0,   8'd100, 1'b0, 8'd100, 5'd26, 1'b1, 1'b0},
            '{8'd30,  8'd100, 1'b1, 8'd186, 5'd26, 1'b1, 1'b0},
            '{8'd60,  8'd100, 1'b0, 8'd40,  5'd26, 1'b1, 1'b0},
            '{8'd90,  8'd100, 1'b1, 8'd246, 5'd10, 1'b1, 1'b0},
            '{8'd120, 8'd100, 1'b0, 8'd20,  5'd20, 1'b0, 1'b0},
            '{8'd150, 8'd100, 1'b1, 8'd50,  5'd26, 1'b0, 1'b0},
            '{8'd100, 8'd100, 1'b0, 8'd0,   5'd0,  1'b0, 1'b1},
            '{8'd101, 8'd100, 1'b1, 8'd1,   5'd1,  1'b0, 1'b0}
        };
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 10) begin
                n_chk++;
                if (obs !== {1'b1, t[c-2].d, t[c-2].s, t[c-2].lt, t[c-2].e}) begin
                    n_err++;
                    $display("FAIL b2b%0d_result: got %h want %h", c - 2, obs,
                             {1'b1, t[c-2].d, t[c-2].s, t[c-2].lt, t[c-2].e});
                end
            end else begin
                n_chk++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle%0d: got %b want 0", c, out_valid);
                end
            end
            if (c < 8) drive(t[c].a, t[c].b, t[c].m);
            else       in_valid = 1'b0;
            #1;
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_in_ready%0d: got %b want 1", c, in_ready);
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        drive(8'd9, 8'd3, 1'b0);
        @(negedge clk);
        drive(8'd3, 8'd9, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_inflight_valid: got %b want 1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_async_clear: got %h want %h", obs, 16'h0000);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stale%0d: got %b want 0", k, out_valid);
            end
        end
        drive(8'd40, 8'd35, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_next_early: got %b want 0", out_valid);
        end
        @(negedge clk);
        n_chk++;
        if (obs !== {1'b1, 8'd5, 5'd5, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_next_result: got %h want %h", obs,
                     {1'b1, 8'd5, 5'd5, 1'b0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
